// File: rtl/ps2_cmd_seq_pkg.sv
// Shared PS/2 host constants and the command sequencer state encoding.
package ps2_cmd_seq_pkg;

  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam int         TIMER_W    = 19;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WACT,
    S_WTX,
    S_WRESP,
    S_RETRY
  } seq_state_e;

endpackage

// File: rtl/ps2_cmd_fifo.sv
// Small synchronous FIFO for queued PS/2 command bytes; head is visible while not empty.
module ps2_cmd_fifo #(
  parameter int AW = 2,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd,
  output logic [DW-1:0] head,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          wr_ok, rd_ok;

  always_comb begin
    full   = (cnt_q == (AW+1)'(DEPTH));
    empty  = (cnt_q == '0);
    wr_ok  = wr && !full;
    rd_ok  = rd && !empty;
    wptr_d = wptr_q + AW'(wr_ok);
    rptr_d = rptr_q + AW'(rd_ok);
    cnt_d  = cnt_q + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wptr_q] <= wr_data;
  end

  assign head  = mem_q[rptr_q];
  assign count = cnt_q;

endmodule

// File: rtl/ps2_cmd_seq.sv
// PS/2 host command sequencer: queues command bytes, sends them one at a time,
// retries on RESEND / transmit error / reply timeout, forwards all other rx bytes.
module ps2_cmd_seq
  import ps2_cmd_seq_pkg::*;
#(
  parameter int FIFO_AW   = 2,
  parameter int MAX_RETRY = 3,
  parameter int RESP_TO   = 319999
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_we,
  input  logic [7:0]         cmd_data,
  output logic               cmd_full,
  output logic [FIFO_AW:0]   cmd_cnt,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  input  logic               tx_active,
  input  logic               tx_err,
  output logic               tx_ena,
  output logic [7:0]         tx_data,
  output logic               fwd_valid,
  output logic [7:0]         fwd_data,
  output logic               busy,
  output logic               err,
  input  logic               err_clr
);

  /* state   | meaning
     S_IDLE  | waiting for a queued command; latches FIFO head into tx_data
     S_ISSUE | tx_ena pulse
     S_WACT  | waiting for transmitter to go busy
     S_WTX   | transmitter busy; on fall check tx_err
     S_WRESP | reply timer running, waiting for ACK / RESEND
     S_RETRY | resend or drop the command once retries are exhausted */

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  seq_state_e         state_q, state_d;
  logic [RW-1:0]      retry_q, retry_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               fwd_valid_q, fwd_valid_d;
  logic [7:0]         fwd_data_q, fwd_data_d;
  logic               err_q, err_d;

  logic [7:0] fifo_head;
  logic       fifo_empty;
  logic       pop, resp_ack, resp_resend, retry_max, drop, err_set;

  ps2_cmd_fifo #(.AW(FIFO_AW), .DW(8)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr      (cmd_we),
    .wr_data (cmd_data),
    .rd      (pop),
    .head    (fifo_head),
    .count   (cmd_cnt),
    .full    (cmd_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!fifo_empty) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WACT;
      S_WACT:  if (tx_active) state_d = S_WTX;
      S_WTX:   if (!tx_active) state_d = tx_err ? S_RETRY : S_WRESP;
      S_WRESP: begin
        if (resp_ack)                      state_d = S_IDLE;
        else if (resp_resend)              state_d = S_RETRY;
        else if (!rx_valid && timer_q == '0) state_d = S_RETRY;
      end
      S_RETRY: state_d = retry_max ? S_IDLE : S_ISSUE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_ena      = (state_q == S_ISSUE);
    busy        = (state_q != S_IDLE) || !fifo_empty;
    resp_ack    = (state_q == S_WRESP) && rx_valid && (rx_data == PS2_ACK);
    resp_resend = (state_q == S_WRESP) && rx_valid && (rx_data == PS2_RESEND);
    retry_max   = (retry_q == RW'(MAX_RETRY));
    drop        = (state_q == S_RETRY) && retry_max;
    pop         = resp_ack || drop;
    err_set     = drop || (cmd_we && cmd_full);
  end

  always_comb begin
    retry_d = retry_q;
    if (resp_ack || drop)        retry_d = '0;
    else if (state_q == S_RETRY) retry_d = retry_q + RW'(1);

    timer_d = timer_q;
    if (state_q == S_WTX && !tx_active && !tx_err) timer_d = TIMER_W'(RESP_TO);
    else if (state_q == S_WRESP && timer_q != '0)  timer_d = timer_q - TIMER_W'(1);

    tx_data_d = (state_q == S_IDLE && !fifo_empty) ? fifo_head : tx_data_q;

    // ACK/RESEND are consumed only while a reply is pending
    fwd_valid_d = rx_valid && !resp_ack && !resp_resend;
    fwd_data_d  = rx_valid ? rx_data : fwd_data_q;

    if (err_set)      err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
    else              err_d = err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retry_q     <= '0;
      timer_q     <= '0;
      tx_data_q   <= '0;
      fwd_valid_q <= 1'b0;
      fwd_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      retry_q     <= retry_d;
      timer_q     <= timer_d;
      tx_data_q   <= tx_data_d;
      fwd_valid_q <= fwd_valid_d;
      fwd_data_q  <= fwd_data_d;
      err_q       <= err_d;
    end
  end

  assign tx_data   = tx_data_q;
  assign fwd_valid = fwd_valid_q;
  assign fwd_data  = fwd_data_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ps2_cmd_seq.sv
// Directed bench for ps2_cmd_seq with a behavioural PS/2 transmitter model.
module tb_ps2_cmd_seq;

  localparam int TB_RESP_TO = 199;
  localparam int TB_AW      = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_we;
  logic [7:0]       cmd_data;
  logic             cmd_full;
  logic [TB_AW:0]   cmd_cnt;
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             tx_active;
  logic             tx_err;
  logic             tx_ena;
  logic [7:0]       tx_data;
  logic             fwd_valid;
  logic [7:0]       fwd_data;
  logic             busy;
  logic             err;
  logic             err_clr;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  int         ena_cnt = 0;
  logic [7:0] ena_data[$];
  int         ena_time[$];
  int         fwd_cnt = 0;

  int   tx_len     = 10;
  logic tx_stall   = 1'b0;
  logic tx_err_cfg = 1'b0;

  ps2_cmd_seq #(.FIFO_AW(TB_AW), .MAX_RETRY(3), .RESP_TO(TB_RESP_TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_we    (cmd_we),
    .cmd_data  (cmd_data),
    .cmd_full  (cmd_full),
    .cmd_cnt   (cmd_cnt),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .tx_active (tx_active),
    .tx_err    (tx_err),
    .tx_ena    (tx_ena),
    .tx_data   (tx_data),
    .fwd_valid (fwd_valid),
    .fwd_data  (fwd_data),
    .busy      (busy),
    .err       (err),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: goes busy one cycle after tx_ena, drops after tx_len cycles.
  initial begin
    tx_active = 1'b0;
    tx_err    = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_ena === 1'b1) begin
        ena_cnt++;
        ena_data.push_back(tx_data);
        ena_time.push_back(cyc);
        tx_active = 1'b1;
        for (int i = 0; i < tx_len && !rst; i++) @(negedge clk);
        while (tx_stall && !rst) @(negedge clk);
        tx_err    = rst ? 1'b0 : tx_err_cfg;
        tx_active = 1'b0;
        @(negedge clk);
        tx_err = 1'b0;
      end
    end
  end

  always @(negedge clk) if (fwd_valid === 1'b1) fwd_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, cycles=%0d required<50000", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ena_byte(input int idx);
    if (idx < ena_data.size()) return {24'h0, ena_data[idx]};
    return 32'hDEAD_BEEF;
  endfunction

  function automatic int ena_at(input int idx);
    if (idx < ena_time.size()) return ena_time[idx];
    return 0;
  endfunction

  task automatic put(input logic [7:0] b);
    cmd_we   = 1'b1;
    cmd_data = b;
    @(negedge clk);
    cmd_we   = 1'b0;
  endtask

  task automatic rx(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_ena(input int target, input int budget);
    int n = 0;
    while (ena_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (ena_cnt < target) check("wait_ena_timeout", ena_cnt, target);
  endtask

  initial begin
    int base;
    int fbase;
    int gap;
    logic [7:0] burst [5];
    burst[0] = 8'h10; burst[1] = 8'h11; burst[2] = 8'h12; burst[3] = 8'h13; burst[4] = 8'h14;

    rst = 1'b1; cmd_we = 1'b0; cmd_data = '0; rx_valid = 1'b0; rx_data = '0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_cnt", cmd_cnt, 0);
    check("rst_full", cmd_full, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_tx_ena", tx_ena, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_fwd_valid", fwd_valid, 0);

    // two commands, both ACKed
    put(8'hED);
    check("lat_ena_early", tx_ena, 0);
    put(8'h02);
    check("lat_ena", tx_ena, 1);
    check("lat_data", tx_data, 8'hED);
    check("two_cnt", cmd_cnt, 2);
    wait_ena(1, 50);
    repeat (100) @(negedge clk);
    rx(8'hFA);
    wait_ena(2, 50);
    repeat (100) @(negedge clk);
    rx(8'hFA);
    repeat (5) @(negedge clk);
    check("two_pulses", ena_cnt, 2);
    check("two_byte0", ena_byte(0), 8'hED);
    check("two_byte1", ena_byte(1), 8'h02);
    check("two_cnt_end", cmd_cnt, 0);
    check("two_err", err, 0);
    check("two_busy", busy, 0);

    // RESEND twice then ACK
    base = ena_cnt;
    put(8'hFF);
    wait_ena(base + 1, 50); repeat (50) @(negedge clk); rx(8'hFE);
    wait_ena(base + 2, 50); repeat (50) @(negedge clk); rx(8'hFE);
    wait_ena(base + 3, 50); repeat (50) @(negedge clk); rx(8'hFA);
    repeat (300) @(negedge clk);
    check("resend_pulses", ena_cnt - base, 3);
    for (int i = 0; i < 3; i++) check("resend_byte", ena_byte(base + i), 8'hFF);
    check("resend_err", err, 0);
    check("resend_cnt", cmd_cnt, 0);

    // no reply: initial attempt + 3 retries, then dropped
    base = ena_cnt;
    put(8'hF4);
    wait_ena(base + 4, 2000);
    repeat (300) @(negedge clk);
    check("to_pulses", ena_cnt - base, 4);
    for (int i = 0; i < 3; i++) begin
      gap = ena_at(base + i + 1) - ena_at(base + i);
      check("to_gap", (gap >= TB_RESP_TO + 1) && (gap <= TB_RESP_TO + 40), 1);
    end
    check("to_err", err, 1);
    check("to_busy", busy, 0);
    check("to_cnt", cmd_cnt, 0);
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    check("to_err_clr", err, 0);

    // forwarding while idle and while waiting for a reply
    base = ena_cnt;
    rx(8'h1C);
    check("fwd_idle_valid", fwd_valid, 1);
    check("fwd_idle_data", fwd_data, 8'h1C);
    @(negedge clk);
    check("fwd_idle_pulse", fwd_valid, 0);
    fbase = fwd_cnt;
    put(8'hEE);
    wait_ena(base + 1, 50);
    repeat (50) @(negedge clk);
    rx(8'hEE);
    check("fwd_wresp_valid", fwd_valid, 1);
    check("fwd_wresp_data", fwd_data, 8'hEE);
    repeat (20) @(negedge clk);
    rx(8'hFA);
    repeat (5) @(negedge clk);
    check("fwd_count", fwd_cnt - fbase, 1);
    check("fwd_pulses", ena_cnt - base, 1);
    check("fwd_cnt_end", cmd_cnt, 0);

    // overflow while transmitter stalls
    base = ena_cnt;
    tx_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cmd_we = 1'b1; cmd_data = burst[i];
      @(negedge clk);
    end
    cmd_we = 1'b0;
    check("ovf_full", cmd_full, 1);
    check("ovf_cnt", cmd_cnt, 4);
    check("ovf_err", err, 1);
    cmd_we = 1'b1; cmd_data = 8'h55; err_clr = 1'b1;
    @(negedge clk);
    cmd_we = 1'b0; err_clr = 1'b0;
    check("ovf_set_wins", err, 1);
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    check("ovf_err_clr", err, 0);
    tx_stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_ena(base + k + 1, 200);
      repeat (30) @(negedge clk);
      rx(8'hFA);
    end
    repeat (10) @(negedge clk);
    check("ovf_pulses", ena_cnt - base, 4);
    for (int k = 0; k < 4; k++) check("ovf_byte", ena_byte(base + k), 32'(burst[k]));
    check("ovf_cnt_end", cmd_cnt, 0);
    check("ovf_full_end", cmd_full, 0);

    // reset while the transmitter is busy
    base = ena_cnt;
    tx_len = 20;
    put(8'hAB);
    wait_ena(base + 1, 50);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_ena", tx_ena, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cnt", cmd_cnt, 0);
    check("mid_rst_err", err, 0);
    repeat (300) @(negedge clk);
    check("mid_rst_quiet", ena_cnt - base, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ps2_cmd_seq.md
Name: ps2_cmd_seq

Overview:
- Host-side command sequencer that sits directly upstream of the PS/2 transmitter and drives its tx_ena and tx_data.
- Buffers command bytes from the CPU bus in a small FIFO and issues them one at a time.
- After each byte, waits for the device reply from the PS/2 receiver:
  - 0xFA (ACK) completes the command.
  - 0xFE (RESEND), a transmit error or a reply timeout triggers a retry, up to a limit.
- All other received bytes pass through to the host unchanged.

Parameters:
- FIFO_AW, 2: log2 of command FIFO depth (4 entries).
- MAX_RETRY, 3: retries after the first attempt before the command is dropped.
- RESP_TO, 319999: reply timeout in clk cycles minus 1 (20 ms at 16 MHz).

Ports:
- clk  in  1  system clock (16 MHz)
- rst  in  1  synchronous active-high reset
- cmd_we  in  1  host write strobe, one byte per cycle
- cmd_data  in  8  command byte
- cmd_full  out  1  FIFO full
- cmd_cnt  out  FIFO_AW+1  FIFO occupancy
- rx_valid  in  1  one-cycle pulse, received byte ready
- rx_data  in  8  received byte
- tx_active  in  1  transmitter busy
- tx_err  in  1  transmitter error flag, valid when tx_active falls
- tx_ena  out  1  one-cycle transmit request
- tx_data  out  8  byte to transmit
- fwd_valid  out  1  one-cycle pulse, forwarded rx byte
- fwd_data  out  8  forwarded rx byte
- busy  out  1  sequencer not idle or FIFO non-empty
- err  out  1  sticky: command dropped or FIFO overflow; cleared by err_clr or rst
- err_clr  in  1  clears err

Behaviour:
- Reset: FIFO empty (cmd_cnt=0, cmd_full=0); state IDLE; tx_ena, fwd_valid, busy and err all 0; tx_data=0; retry count 0. Reset mid-transfer aborts at once with no tx_ena pulse; the transmitter is reset by the same rst.

FIFO:
- Write when cmd_we and not full.
- cmd_we while full: byte discarded, err set.
- Head is popped only on completion or drop.
- Write and pop in the same cycle: count unchanged.
- Pointers wrap modulo 2^FIFO_AW.

State machine:
- IDLE: if FIFO not empty, go to ISSUE. tx_data takes the FIFO head.
- ISSUE: tx_ena=1 for exactly this cycle; go to WACT.
- WACT: wait for tx_active=1; go to WTX. tx_active is expected 1 cycle after tx_ena.
- WTX: wait for tx_active=0.
  - If tx_err=1, go to RETRY.
  - Otherwise load timer=RESP_TO and go to WRESP.
- WRESP:
  - rx_valid with 0xFA: pop, clear retry count, go to IDLE.
  - rx_valid with 0xFE: go to RETRY.
  - rx_valid with any other byte: forward it and stay.
  - timer==0: go to RETRY.
  - Otherwise timer decrements by 1.
- RETRY:
  - If retry count == MAX_RETRY: pop, set err, clear count, go to IDLE.
  - Otherwise increment count and go to ISSUE.
- rx_valid outside WRESP: byte forwarded (fwd_valid next cycle, fwd_data registered).
- Latency: cmd_we into an empty FIFO → tx_ena high 2 cycles later.
- Reply timer is 19 bits wide.
- err_clr and a new error event in the same cycle: err=1 (set wins).

Decomposition:
- Shared ps2 package holds the constants PS2_ACK=8'hFA and PS2_RESEND=8'hFE.
- Sub-module ps2_cmd_fifo: a parameterized synchronous FIFO providing wr, rd, head, count, full and empty.

Test Plan:
- Write 0xED then 0x02; model the transmitter completing both with tx_err=0, reply 0xFA after 100 cycles each → two tx_ena pulses with tx_data 0xED then 0x02; cmd_cnt ends 0; err=0.
- Write 0xFF; reply 0xFE twice, then 0xFA → exactly 3 tx_ena pulses, all 0xFF; err=0.
- Write 0xF4; never reply → 4 tx_ena pulses spaced by at least 320000 cycles; then pop, err=1, busy=0.
- Write 0xEE; reply 0xEE, then 0xFA → one fwd_valid with 0xEE, command completes; also inject a rx_valid 0x1C while IDLE → forwarded.
- Write 5 bytes back-to-back while the transmitter stalls → 5th byte dropped, cmd_full=1, err=1; err_clr then clears err.
- Assert rst during WTX → next cycle tx_ena=0, busy=0, cmd_cnt=0; no further tx_ena without new writes.
